// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - program sequencer / instruction fetcher (one instruction in flight).
// Optional `FETCH_COUNT_EN adds a saturating 16-bit decoder-handshake counter output.
module instr_fetch_seq #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_wen,
`ifdef FETCH_COUNT_EN
  output logic              halted,
  output logic [15:0]       fetch_count
`else
  output logic              halted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DELIVER = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc_out;
  logic              r_pc_wen;
  logic              w_ack_take;
  logic              w_handshake;

  // Acks outside REQ and ready without a pending instruction are simply not qualified.
  assign w_ack_take  = (r_state == S_REQ) && mem_ack;
  assign w_handshake = (r_state == S_DELIVER) && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_next_state = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (instr_ready) begin
          if (halt) begin
            w_next_state = S_HALT;
          end else if (run) begin
            w_next_state = S_REQ;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State-decoded outputs so an asynchronous reset drops mem_req at once.
  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_REQ:     mem_req     = 1'b1;
      S_DELIVER: instr_valid = 1'b1;
      S_HALT:    halted      = 1'b1;
      default: begin
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_ADDR;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_pc_wen <= 1'b0;
    end else begin
      r_pc_wen <= 1'b0;
      if (w_ack_take) begin
        r_instr  <= mem_rdata;
        r_pc_out <= r_pc;
        r_pc_wen <= 1'b1;
      end
      // Halt wins over jump and leaves the PC on the instruction that halted.
      if (w_handshake && !halt) begin
        if (jump_en) begin
          r_pc <= jump_addr;
        end else begin
          r_pc <= r_pc + ADDR_W'(1);
        end
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_handshake && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

  assign mem_addr = r_pc;
  assign instr    = r_instr;
  assign pc_out   = r_pc_out;
  assign pc_wen   = r_pc_wen;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - directed plus randomized bench for instr_fetch_seq, two RESET_ADDR instances.
module tb_instr_fetch_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       instr_ready = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic       halt = 1'b0;

  logic [1:0]       mem_req_o;
  logic [1:0][7:0]  mem_addr_o;
  logic [1:0][7:0]  instr_o;
  logic [1:0]       instr_valid_o;
  logic [1:0][7:0]  pc_out_o;
  logic [1:0]       pc_wen_o;
  logic [1:0]       halted_o;
  logic [1:0][15:0] fcount_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_seq #(.ADDR_W(8), .DATA_W(8), .RESET_ADDR(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req_o[0]), .mem_addr(mem_addr_o[0]),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr_o[0]), .instr_valid(instr_valid_o[0]), .instr_ready(instr_ready),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
    .pc_out(pc_out_o[0]), .pc_wen(pc_wen_o[0]),
`ifdef FETCH_COUNT_EN
    .halted(halted_o[0]), .fetch_count(fcount_o[0])
`else
    .halted(halted_o[0])
`endif
  );

  instr_fetch_seq #(.ADDR_W(8), .DATA_W(8), .RESET_ADDR(8'hFE)) u_dut1 (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req_o[1]), .mem_addr(mem_addr_o[1]),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr_o[1]), .instr_valid(instr_valid_o[1]), .instr_ready(instr_ready),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
    .pc_out(pc_out_o[1]), .pc_wen(pc_wen_o[1]),
`ifdef FETCH_COUNT_EN
    .halted(halted_o[1]), .fetch_count(fcount_o[1])
`else
    .halted(halted_o[1])
`endif
  );

`ifndef FETCH_COUNT_EN
  assign fcount_o = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: what each sequencer is doing, where its PC is, what it last fetched.
  localparam int P_WAIT = 0, P_FETCH = 1, P_HOLD = 2, P_STOP = 3;
  typedef struct {
    int          phase;
    logic [7:0]  pc;
    logic [7:0]  instr;
    logic [7:0]  pc_out;
    logic        wen;
    int          handshakes;
  } mdl_t;
  mdl_t m[2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m[k].phase = P_WAIT;
        m[k].pc = (k == 0) ? 8'h00 : 8'hFE;
        m[k].instr = 8'h00;
        m[k].pc_out = 8'h00;
        m[k].wen = 1'b0;
        m[k].handshakes = 0;
      end else begin
        m[k].wen = 1'b0;
        if (m[k].phase == P_WAIT) begin
          if (run) m[k].phase = P_FETCH;
        end else if (m[k].phase == P_FETCH) begin
          if (mem_ack) begin
            m[k].instr = mem_rdata;
            m[k].pc_out = m[k].pc;
            m[k].wen = 1'b1;
            m[k].phase = P_HOLD;
          end
        end else if (m[k].phase == P_HOLD) begin
          if (instr_ready) begin
            m[k].handshakes++;
            if (halt) begin
              m[k].phase = P_STOP;
            end else begin
              m[k].pc = jump_en ? jump_addr : 8'((int'(m[k].pc) + 1) % 256);
              m[k].phase = run ? P_FETCH : P_WAIT;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d.mem_req", k), 32'(mem_req_o[k]), 32'(m[k].phase == P_FETCH));
      chk($sformatf("m%0d.instr_valid", k), 32'(instr_valid_o[k]), 32'(m[k].phase == P_HOLD));
      chk($sformatf("m%0d.halted", k), 32'(halted_o[k]), 32'(m[k].phase == P_STOP));
      chk($sformatf("m%0d.pc_wen", k), 32'(pc_wen_o[k]), 32'(m[k].wen));
      chk($sformatf("m%0d.instr", k), 32'(instr_o[k]), 32'(m[k].instr));
      chk($sformatf("m%0d.pc_out", k), 32'(pc_out_o[k]), 32'(m[k].pc_out));
      if (m[k].phase == P_FETCH)
        chk($sformatf("m%0d.mem_addr", k), 32'(mem_addr_o[k]), 32'(m[k].pc));
`ifdef FETCH_COUNT_EN
      chk($sformatf("m%0d.fetch_count", k), 32'(fcount_o[k]),
          32'((m[k].handshakes > 65535) ? 65535 : m[k].handshakes));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req_o[0] && n < 50) begin
      step();
      n++;
    end
    chk("wait_req_timeout", 32'(mem_req_o[0]), 32'd1);
  endtask

  // Issue one ack with the given data from a REQ cycle; returns on the DELIVER cycle.
  task automatic fetch(input logic [7:0] d);
    wait_req();
    mem_ack = 1'b1;
    mem_rdata = d;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    chk("rst.mem_req", 32'(mem_req_o[0]), 32'd0);
    chk("rst.mem_addr0", 32'(mem_addr_o[0]), 32'h00);
    chk("rst.mem_addr1", 32'(mem_addr_o[1]), 32'hFE);
    chk("rst.instr", 32'(instr_o[0]), 32'h00);
    chk("rst.pc_out1", 32'(pc_out_o[1]), 32'h00);
    chk("rst.halted", 32'(halted_o[0]), 32'd0);
    #2 rst = 1'b0;
    step();
    run = 1'b1;
    instr_ready = 1'b1;
    step();
    chk("f1.mem_req", 32'(mem_req_o[0]), 32'd1);
    chk("f1.mem_addr0", 32'(mem_addr_o[0]), 32'h00);
    chk("f1.mem_addr1", 32'(mem_addr_o[1]), 32'hFE);
    mem_ack = 1'b1;
    mem_rdata = 8'hA5;
    step();
    mem_ack = 1'b0;
    chk("f1.instr", 32'(instr_o[0]), 32'hA5);
    chk("f1.valid", 32'(instr_valid_o[0]), 32'd1);
    chk("f1.pc_wen", 32'(pc_wen_o[0]), 32'd1);
    chk("f1.pc_out0", 32'(pc_out_o[0]), 32'h00);
    chk("f1.pc_out1", 32'(pc_out_o[1]), 32'hFE);
    step();
    chk("f2.mem_addr0", 32'(mem_addr_o[0]), 32'h01);
    chk("f2.mem_addr1", 32'(mem_addr_o[1]), 32'hFF);
    chk("f2.pc_wen", 32'(pc_wen_o[0]), 32'd0);

    instr_ready = 1'b0;
    fetch(8'h3C);
    chk("f2.pc_wen_pulse", 32'(pc_wen_o[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall.valid", 32'(instr_valid_o[0]), 32'd1);
      chk("stall.instr", 32'(instr_o[0]), 32'h3C);
      chk("stall.no_req", 32'(mem_req_o[0]), 32'd0);
      chk("stall.pc_wen", 32'(pc_wen_o[0]), 32'd0);
    end
    instr_ready = 1'b1;
    step();
    chk("f3.mem_addr0", 32'(mem_addr_o[0]), 32'h02);
    chk("f3.mem_addr1_wrap", 32'(mem_addr_o[1]), 32'h00);

    jump_en = 1'b1;
    jump_addr = 8'h40;
    fetch(8'h11);
    step();
    jump_en = 1'b0;
    chk("jump.mem_addr0", 32'(mem_addr_o[0]), 32'h40);
    chk("jump.mem_addr1", 32'(mem_addr_o[1]), 32'h40);

    halt = 1'b1;
    jump_en = 1'b1;
    jump_addr = 8'h77;
    fetch(8'h22);
    chk("halt.pc_out", 32'(pc_out_o[0]), 32'h40);
    step();
    halt = 1'b0;
    jump_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("halt.halted", 32'(halted_o[0]), 32'd1);
      chk("halt.no_req", 32'(mem_req_o[0]), 32'd0);
      mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("halt.pc_kept", 32'(mem_addr_o[0]), 32'h40);

    #1 rst = 1'b1;
    #2 rst = 1'b0;
    wait_req();
    #2 rst = 1'b1;
    #1;
    chk("arst.mem_req0", 32'(mem_req_o[0]), 32'd0);
    chk("arst.mem_req1", 32'(mem_req_o[1]), 32'd0);
    run = 1'b0;
    mem_ack = 1'b1;
    step();
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst.no_valid", 32'(instr_valid_o[0]), 32'd0);
      chk("arst.no_wen", 32'(pc_wen_o[0]), 32'd0);
    end
    mem_ack = 1'b0;
    run = 1'b1;
    wait_req();
    chk("arst.restart0", 32'(mem_addr_o[0]), 32'h00);
    chk("arst.restart1", 32'(mem_addr_o[1]), 32'hFE);

    run = 1'b0;
    step();
    step();
    chk("norun.still_req", 32'(mem_req_o[0]), 32'd1);
    fetch(8'h5A);
    chk("norun.valid", 32'(instr_valid_o[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("norun.no_req", 32'(mem_req_o[0]), 32'd0);
    end
`ifdef FETCH_COUNT_EN
    chk("norun.fetch_count", 32'(fcount_o[0]), 32'd1);
`endif

    for (int c = 0; c < 4000; c++) begin
      run = ($urandom % 8) != 0;
      mem_ack = $urandom % 2;
      mem_rdata = 8'($urandom);
      instr_ready = ($urandom % 3) != 0;
      jump_en = ($urandom % 4) == 0;
      jump_addr = 8'($urandom);
      halt = ($urandom % 40) == 0;
      if ((halted_o[0] && ($urandom % 6) == 0) || ($urandom % 300) == 0) begin
        #1 rst = 1'b1;
        #1;
        chk("rnd.arst_req", 32'(mem_req_o[0]), 32'd0);
        #1 rst = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
